// File: rtl/hex_tx_pkg.sv
// hex_tx_pkg: shared state encoding and ASCII constants for the hex digest serializer.
package hex_tx_pkg;

    typedef enum logic [2:0] {IDLE, HEX, CR, LF, FIN} state_t;

    localparam logic [7:0] CHAR_CR   = 8'h0D;
    localparam logic [7:0] CHAR_LF   = 8'h0A;
    localparam logic [7:0] CHAR_0    = 8'h30;
    localparam logic [7:0] CHAR_A_LO = 8'h61;
    localparam logic [7:0] CHAR_A_UP = 8'h41;

endpackage

// File: rtl/nibble_to_ascii.sv
// nibble_to_ascii: combinational map of a 4-bit value to its ASCII hex character.
module nibble_to_ascii #(
    parameter bit UPPERCASE = 1'b0
) (
    input  logic [3:0] nibble,
    output logic [7:0] ascii
);
    import hex_tx_pkg::*;

    assign ascii = (nibble < 4'd10) ? CHAR_0 + {4'h0, nibble}
                                    : (UPPERCASE ? CHAR_A_UP : CHAR_A_LO) + {4'h0, nibble} - 8'd10;

endmodule

// File: rtl/hex_digest_tx.sv
// hex_digest_tx: captures a digest on start and streams it as ASCII hex bytes over valid/ready,
// optionally followed by CR/LF, with a one-cycle done pulse at the end.
module hex_digest_tx #(
    parameter int D         = 512,
    parameter bit MSB_FIRST = 1'b1,
    parameter bit UPPERCASE = 1'b0,
    parameter bit TERM_EN   = 1'b1
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [D-1:0] digest,
    output logic         busy,
    output logic         done,
    output logic [7:0]   out_data,
    output logic         out_valid,
    input  logic         out_ready
);
    import hex_tx_pkg::*;

    localparam int N  = D / 4;
    localparam int CW = $clog2(N);

    state_t        state, state_nx;
    logic [CW-1:0] cnt, cnt_nx, sel;
    logic [D-1:0]  cap;
    logic [3:0]    nib;
    logic [7:0]    hex_char;
    logic          xfer, last;

    assign xfer = out_valid & out_ready;
    assign last = cnt == CW'(N - 1);

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        unique case (state)
            IDLE: if (start) begin
                state_nx = HEX;
                cnt_nx   = '0;
            end
            HEX: if (xfer) begin
                if (last) state_nx = TERM_EN ? CR : FIN;
                else cnt_nx = cnt + 1'b1;
            end
            CR:  if (xfer) state_nx = LF;
            LF:  if (xfer) state_nx = FIN;
            FIN: state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            cap       <= '0;
            out_valid <= 1'b0;
        end else begin
            state     <= state_nx;
            cnt       <= cnt_nx;
            out_valid <= state_nx inside {HEX, CR, LF};
            if (state == IDLE && start) cap <= digest;
        end
    end

    // Counter position k maps to nibble index from the top or bottom of the capture.
    assign sel = MSB_FIRST ? CW'(N - 1) - cnt : cnt;
    assign nib = cap[{sel, 2'b00} +: 4];

    nibble_to_ascii #(.UPPERCASE(UPPERCASE)) u_n2a (
        .nibble(nib),
        .ascii (hex_char)
    );

    assign out_data = (state == HEX) ? hex_char
                    : (state == CR)  ? CHAR_CR
                    : (state == LF)  ? CHAR_LF
                    : 8'h00;
    assign busy = state inside {HEX, CR, LF};
    assign done = state == FIN;

endmodule

// File: tb/tb_hex_digest_tx.sv
// tb_hex_digest_tx: three configurations checked against hand-written byte tables and a
// SHA3-512("abc") reference string through per-instance expected-byte queues.
module tb_hex_digest_tx;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic ab_start = 1'b0, c_start = 1'b0;
    logic [15:0]  dg16 = '0;
    logic [511:0] dg512 = '0;
    logic a_busy, a_done, a_valid, b_busy, b_done, b_valid, c_busy, c_done, c_valid;
    logic [7:0] a_data, b_data, c_data;
    logic a_ready = 1'b1, b_ready = 1'b1, c_ready = 1'b0;

    always #5 clk = ~clk;

    hex_digest_tx #(.D(16), .MSB_FIRST(1'b1), .UPPERCASE(1'b0), .TERM_EN(1'b1)) u_a (
        .clk(clk), .reset(reset), .start(ab_start), .digest(dg16), .busy(a_busy), .done(a_done),
        .out_data(a_data), .out_valid(a_valid), .out_ready(a_ready));

    hex_digest_tx #(.D(16), .MSB_FIRST(1'b0), .UPPERCASE(1'b1), .TERM_EN(1'b0)) u_b (
        .clk(clk), .reset(reset), .start(ab_start), .digest(dg16), .busy(b_busy), .done(b_done),
        .out_data(b_data), .out_valid(b_valid), .out_ready(b_ready));

    hex_digest_tx #(.D(512), .MSB_FIRST(1'b1), .UPPERCASE(1'b0), .TERM_EN(1'b1)) u_c (
        .clk(clk), .reset(reset), .start(c_start), .digest(dg512), .busy(c_busy), .done(c_done),
        .out_data(c_data), .out_valid(c_valid), .out_ready(c_ready));

    typedef struct {
        logic [15:0] dg;
        logic [47:0] a;
        logic [31:0] b;
    } vec_t;

    vec_t vec[5];
    int n = 0, miss = 0;
    logic [7:0] qa[$], qb[$], qc[$];
    bit a_last, b_last, c_last, c_stall;
    logic [7:0] c_prev;
    int a_bc, b_bc;
    string ref_s = "b751850b1a57168a5693cd924b6b096e08f621827444f70d884f5d0240d2712e10e116e9192af3c91a7ec57647e3934057340b4cf408d5a56592f8274eec53f0";

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n++;
        if (act !== exp) begin
            miss++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic push_ab(input int i);
        for (int j = 0; j < 6; j++) qa.push_back(vec[i].a[47-8*j -: 8]);
        for (int j = 0; j < 4; j++) qb.push_back(vec[i].b[31-8*j -: 8]);
    endtask

    // Observes outputs mid-cycle: a transfer seen here happens on the next rising edge.
    task automatic mon();
        if (reset) begin
            qa.delete(); qb.delete(); qc.delete();
            a_last = 0; b_last = 0; c_last = 0; c_stall = 0; a_bc = 0; b_bc = 0;
            return;
        end
        if (a_valid && a_ready) begin
            chk("a_byte_expected", 64'(qa.size() != 0), 1);
            if (qa.size() != 0) chk("a_byte", a_data, qa.pop_front());
        end
        chk("a_done", a_done, a_last);
        a_last = a_valid && a_ready && qa.size() == 0;
        if (a_busy) a_bc++;
        if (a_done) begin chk("a_busy_len", a_bc, 6); a_bc = 0; end
        if (b_valid && b_ready) begin
            chk("b_byte_expected", 64'(qb.size() != 0), 1);
            if (qb.size() != 0) chk("b_byte", b_data, qb.pop_front());
        end
        chk("b_done", b_done, b_last);
        b_last = b_valid && b_ready && qb.size() == 0;
        if (b_busy) b_bc++;
        if (b_done) begin chk("b_busy_len", b_bc, 4); b_bc = 0; end
        if (c_stall) begin
            chk("c_stall_valid", c_valid, 1);
            chk("c_stall_data", c_data, c_prev);
        end
        if (c_valid && c_ready) begin
            chk("c_byte_expected", 64'(qc.size() != 0), 1);
            if (qc.size() != 0) chk("c_byte", c_data, qc.pop_front());
        end
        chk("c_done", c_done, c_last);
        c_last = c_valid && c_ready && qc.size() == 0;
        c_stall = c_valid && !c_ready;
        c_prev = c_data;
    endtask

    task automatic step();
        @(negedge clk);
        mon();
        @(posedge clk);
        #1;
    endtask

    initial begin
        vec[0] = '{16'hA5F0, 48'h6135_6630_0D0A, 32'h3046_3541};
        vec[1] = '{16'h0000, 48'h3030_3030_0D0A, 32'h3030_3030};
        vec[2] = '{16'hFFFF, 48'h6666_6666_0D0A, 32'h4646_4646};
        vec[3] = '{16'h1234, 48'h3132_3334_0D0A, 32'h3433_3231};
        vec[4] = '{16'h9ABC, 48'h3961_6263_0D0A, 32'h4342_4139};

        step(); step();
        chk("rst_valid", a_valid, 0);
        chk("rst_busy", a_busy, 0);
        chk("rst_done", a_done, 0);
        chk("rst_data", a_data, 0);
        chk("rst_c_valid", c_valid, 0);
        reset = 1'b0;
        step();

        // Table vectors; digest is inverted right after start to prove it was captured.
        for (int i = 0; i < 5; i++) begin
            ab_start = 1'b1;
            dg16 = vec[i].dg;
            push_ab(i);
            step();
            ab_start = 1'b0;
            dg16 = ~dg16;
            chk("first_valid", a_valid, 1);
            chk("first_busy", a_busy, 1);
            chk("first_data", a_data, vec[i].a[47:40]);
            repeat (9) step();
            chk("a_queue_drained", qa.size(), 0);
            chk("b_queue_drained", qb.size(), 0);
        end

        // Second start mid-message must be ignored.
        ab_start = 1'b1;
        dg16 = vec[0].dg;
        push_ab(0);
        step();
        ab_start = 1'b0;
        step(); step();
        ab_start = 1'b1;
        dg16 = vec[3].dg;
        step();
        ab_start = 1'b0;
        repeat (10) step();
        chk("mid_start_a_drained", qa.size(), 0);
        chk("mid_start_b_drained", qb.size(), 0);

        // Asynchronous reset after the third transfer, then a full resend.
        ab_start = 1'b1;
        dg16 = vec[4].dg;
        push_ab(4);
        step();
        ab_start = 1'b0;
        repeat (3) step();
        chk("pre_reset_a_left", qa.size(), 3);
        reset = 1'b1;
        #1;
        chk("arst_a_valid", a_valid, 0);
        chk("arst_a_busy", a_busy, 0);
        chk("arst_a_done", a_done, 0);
        chk("arst_b_valid", b_valid, 0);
        step();
        reset = 1'b0;
        step();
        ab_start = 1'b1;
        dg16 = vec[4].dg;
        push_ab(4);
        step();
        ab_start = 1'b0;
        chk("post_reset_first", a_data, vec[4].a[47:40]);
        repeat (9) step();
        chk("post_reset_a_drained", qa.size(), 0);
        chk("post_reset_b_drained", qb.size(), 0);

        // SHA3-512("abc") under random backpressure.
        c_start = 1'b1;
        dg512 = 512'hb751850b1a57168a5693cd924b6b096e08f621827444f70d884f5d0240d2712e10e116e9192af3c91a7ec57647e3934057340b4cf408d5a56592f8274eec53f0;
        for (int k = 0; k < 128; k++) qc.push_back(ref_s[k]);
        qc.push_back(8'h0D);
        qc.push_back(8'h0A);
        step();
        c_start = 1'b0;
        dg512 = ~dg512;
        for (int k = 0; k < 2000 && qc.size() != 0; k++) begin
            c_ready = 1'($urandom_range(0, 1));
            step();
        end
        c_ready = 1'b1;
        repeat (4) step();
        chk("c_queue_drained", qc.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", n, miss);
        $finish;
    end

endmodule
